// File: rtl/gtp_pll0_reset_seq_if.sv
// Purpose : Control/status bundle between the PLL0 reset sequencer and its user (PLL pins plus ready/fail status).
// Ports   : enable and pll_lock go into the sequencer; pll_pd, pll_reset, pll_ready, fail and retry_count come out of it.
// Modports: slave = sequencer side, master = driving/observing side (system logic or bench).
interface gtp_pll0_reset_seq_if;
    logic       enable;       // level request for PLL bring-up
    logic       pll_lock;     // raw PLL0LOCK, asynchronous to clk
    logic       pll_pd;       // to PLL0PD
    logic       pll_reset;    // to PLL0RESET
    logic       pll_ready;    // PLL locked and stable
    logic       fail;         // sticky unrecoverable-PLL flag
    logic [3:0] retry_count;  // retries consumed since leaving IDLE

    modport slave (
        input  enable,
        input  pll_lock,
        output pll_pd,
        output pll_reset,
        output pll_ready,
        output fail,
        output retry_count
    );

    modport master (
        output enable,
        output pll_lock,
        input  pll_pd,
        input  pll_reset,
        input  pll_ready,
        input  fail,
        input  retry_count
    );
endinterface

// File: rtl/gtp_pll0_reset_seq.sv
// Purpose : Power-up / reset / lock-qualify sequencer for a GTPE2_COMMON PLL0, with bounded retry and a sticky fail flag.
// Ports   : clk, rst (sync, active-high); pll_if.slave carries enable/pll_lock in and pll_pd/pll_reset/pll_ready/fail/retry_count out.
// Timing  : Moore machine, every output decoded from registered state; pll_lock reaches the FSM through a 2-flop synchronizer.
module gtp_pll0_reset_seq #(
    parameter int POWERUP_WAIT = 8192,   // cycles powered up before the reset pulse
    parameter int RESET_PULSE  = 16,     // cycles pll_reset is held high
    parameter int LOCK_TIMEOUT = 65536,  // max cycles waiting for lock before a retry
    parameter int LOCK_STABLE  = 1024,   // consecutive locked cycles before ready
    parameter int MAX_RETRIES  = 3       // retries before FAIL, legal range 1..15
) (
    input  logic                       clk,
    input  logic                       rst,
    gtp_pll0_reset_seq_if.slave        pll_if
);

    // ------------------------------------------------------------------
    // Counter widths and terminal values
    // ------------------------------------------------------------------
    localparam int PU_W = $clog2(POWERUP_WAIT) + 1;
    localparam int RP_W = $clog2(RESET_PULSE) + 1;
    localparam int TO_W = $clog2(LOCK_TIMEOUT) + 1;
    localparam int ST_W = $clog2(LOCK_STABLE) + 1;

    // Each counter starts at 0 on state entry, so the state's last cycle is N-1.
    localparam logic [PU_W-1:0] PU_LAST = PU_W'(POWERUP_WAIT - 1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(RESET_PULSE - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(LOCK_STABLE - 1);
    localparam logic [3:0]      RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POWERUP,
        S_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_READY,
        S_RETRY,
        S_FAIL
    } state_t;

    state_t            state_q, state_d;
    logic [PU_W-1:0]   pu_cnt_q, pu_cnt_d;
    logic [RP_W-1:0]   rp_cnt_q, rp_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [ST_W-1:0]   st_cnt_q, st_cnt_d;
    logic [3:0]        retry_q, retry_d;

    // ------------------------------------------------------------------
    // Lock synchronizer: lock_s_q in cycle n reflects pll_lock in cycle n-2.
    // ------------------------------------------------------------------
    logic lock_meta_q;
    logic lock_s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_if.pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Terminal-count decodes
    // ------------------------------------------------------------------
    logic pu_done;
    logic rp_done;
    logic to_done;
    logic st_done;

    assign pu_done = (pu_cnt_q == PU_LAST);
    assign rp_done = (rp_cnt_q == RP_LAST);
    assign to_done = (to_cnt_q == TO_LAST);
    // Only reachable while lock_s has stayed high since STABLE entry.
    assign st_done = lock_s_q && (st_cnt_q == ST_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;

        if ((state_q != S_IDLE) && !pll_if.enable) begin
            // Dropping enable beats every other transition, including FAIL hold.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pll_if.enable) state_d = S_POWERUP;
                end
                S_POWERUP: begin
                    if (pu_done) state_d = S_RESET;
                end
                S_RESET: begin
                    if (rp_done) state_d = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    // Lock is tested first so a lock arriving on the timeout
                    // cycle is not thrown away as a retry.
                    if (lock_s_q)     state_d = S_STABLE;
                    else if (to_done) state_d = S_RETRY;
                end
                S_STABLE: begin
                    // A glitch restarts the lock wait with a fresh timer and
                    // does not consume a retry.
                    if (!lock_s_q)    state_d = S_WAIT_LOCK;
                    else if (st_done) state_d = S_READY;
                end
                S_READY: begin
                    if (!lock_s_q) state_d = S_RETRY;
                end
                S_RETRY: begin
                    if (retry_q == RETRY_MAX) state_d = S_FAIL;
                    else                      state_d = S_RESET;
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Counter and retry next-state
    // ------------------------------------------------------------------
    logic stay;

    always_comb begin
        // A counter only advances while its own state persists; any state
        // change (including re-entry from another state) starts it at zero.
        stay     = (state_d == state_q);
        pu_cnt_d = '0;
        rp_cnt_d = '0;
        to_cnt_d = '0;
        st_cnt_d = '0;
        retry_d  = retry_q;

        if (stay) begin
            case (state_q)
                S_POWERUP:   pu_cnt_d = pu_cnt_q + 1'b1;
                S_RESET:     rp_cnt_d = rp_cnt_q + 1'b1;
                S_WAIT_LOCK: to_cnt_d = to_cnt_q + 1'b1;
                S_STABLE:    st_cnt_d = st_cnt_q + 1'b1;
                default:     ;
            endcase
        end

        if (state_d == S_IDLE) begin
            retry_d = '0;
        end else if ((state_q == S_RETRY) && (state_d == S_RESET)) begin
            // Only taken when retry_q < MAX_RETRIES, so the count saturates there.
            retry_d = retry_q + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pu_cnt_q <= '0;
            rp_cnt_q <= '0;
            to_cnt_q <= '0;
            st_cnt_q <= '0;
            retry_q  <= '0;
        end else begin
            state_q  <= state_d;
            pu_cnt_q <= pu_cnt_d;
            rp_cnt_q <= rp_cnt_d;
            to_cnt_q <= to_cnt_d;
            st_cnt_q <= st_cnt_d;
            retry_q  <= retry_d;
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    assign pll_if.pll_pd      = (state_q == S_IDLE) || (state_q == S_FAIL);
    assign pll_if.pll_reset   = (state_q == S_RESET);
    assign pll_if.pll_ready   = (state_q == S_READY);
    assign pll_if.fail        = (state_q == S_FAIL);
    assign pll_if.retry_count = retry_q;

endmodule
